alb_seq: RTL and testbench

ALB_SEQ -- requirements
Module: alb_seq

---
 rtl/alb_seq_pkg.sv | 8 +
 rtl/alb_seq_alb.sv | 24 ++
 rtl/alb_seq.sv | 77 +++++++
 tb/tb_alb_seq.sv | 115 +++++++++++
 4 files changed

// File: rtl/alb_seq_pkg.sv
// alb_seq_pkg: op encodings and FSM state shared by the byte-serial ALB sequencer
package alb_seq_pkg;
  localparam logic [1:0] OP_OR  = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/alb_seq_alb.sv
// alb_seq_alb: 8-bit arithmetic/logic block; SUB computes S + ~R + CI
module alb_seq_alb
  import alb_seq_pkg::*;
(
  input  logic [7:0] r,
  input  logic [7:0] s,
  input  logic [1:0] mi,
  input  logic       ci,
  output logic [7:0] f,
  output logic       co,
  output logic       vo
);
  logic [7:0] b;
  logic [8:0] sum;
  logic       arith;
  always_comb begin
    arith = (mi == OP_ADD) || (mi == OP_SUB);
    b = (mi == OP_SUB) ? ~r : r;
    sum = {1'b0, s} + {1'b0, b} + {8'd0, ci};
    f = (mi == OP_OR) ? (r | s) : (mi == OP_XOR) ? (r ^ s) : sum[7:0];
    co = arith & sum[8];
    vo = arith & (s[7] == b[7]) & (sum[7] != s[7]);
  end
endmodule

// File: rtl/alb_seq.sv
// alb_seq: runs a 32-bit op through one 8-bit ALB, one byte per cycle, LSB first
module alb_seq
  import alb_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [1:0]  cmd_len,
  input  logic [31:0] cmd_r,
  input  logic [31:0] cmd_s,
  input  logic        cmd_ci,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_f,
  output logic        res_co,
  output logic        res_zo,
  output logic        res_no,
  output logic        res_vo,
  output logic        busy
);
  state_t      state, nxt;
  logic [1:0]  op_q, len_q, idx;
  logic [31:0] r_q, s_q;
  logic        ci_q;
  logic [7:0]  f;
  logic        co, vo, last;

  assign last = (idx == len_q);

  alb_seq_alb u_alb (
    .r  (r_q[{idx, 3'b000} +: 8]),
    .s  (s_q[{idx, 3'b000} +: 8]),
    .mi (op_q),
    .ci ((idx == 2'd0) ? ci_q : res_co),
    .f  (f),
    .co (co),
    .vo (vo)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;

  always_comb
    case (state)
      IDLE:    nxt = cmd_valid ? RUN : IDLE;
      RUN:     nxt = last ? DONE : RUN;
      DONE:    nxt = res_ready ? IDLE : DONE;
      default: nxt = IDLE;
    endcase

  always_comb begin
    cmd_ready = (state == IDLE);
    busy = (state != IDLE);
    res_valid = (state == DONE);
  end

  // res_co doubles as the inter-byte carry register feeding the next byte's CI
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {op_q, len_q, idx, r_q, s_q, ci_q} <= '0;
      {res_f, res_co, res_zo, res_no, res_vo} <= '0;
    end else if (state == IDLE && cmd_valid) begin
      {op_q, len_q, r_q, s_q, ci_q} <= {cmd_op, cmd_len, cmd_r, cmd_s, cmd_ci};
      idx <= 2'd0;
      {res_f, res_co, res_zo, res_no, res_vo} <= '0;
    end else if (state == RUN) begin
      res_f[{idx, 3'b000} +: 8] <= f;
      res_co <= co;
      res_vo <= vo;
      res_no <= f[7];
      res_zo <= (f == 8'd0) && (idx == 2'd0 || res_zo);
      idx <= last ? 2'd0 : idx + 2'd1;
    end
endmodule

// File: tb/tb_alb_seq.sv
// tb_alb_seq: directed vectors with hand-computed results for alb_seq
module tb_alb_seq;
  import alb_seq_pkg::*;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_ci = 1'b0;
  logic [1:0]  cmd_op = '0, cmd_len = '0;
  logic [31:0] cmd_r = '0, cmd_s = '0, res_f;
  logic        res_valid, res_ready = 1'b0;
  logic        res_co, res_zo, res_no, res_vo, busy;
  int checks = 0, errors = 0;

  alb_seq dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_r(cmd_r), .cmd_s(cmd_s), .cmd_ci(cmd_ci),
    .res_valid(res_valid), .res_ready(res_ready), .res_f(res_f),
    .res_co(res_co), .res_zo(res_zo), .res_no(res_no), .res_vo(res_vo), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // offer a command, accept it, then count edges until res_valid (acceptance edge = 1)
  task automatic issue(input logic [1:0] op, input logic [1:0] len, input logic [31:0] r,
                       input logic [31:0] s, input logic ci);
    int n;
    {cmd_op, cmd_len, cmd_r, cmd_s, cmd_ci} = {op, len, r, s, ci};
    cmd_valid = 1'b1;
    chk("ready_at_offer", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_r = ~r; cmd_s = $urandom; cmd_ci = ~ci; cmd_op = ~op;
    chk("busy_in_run", {31'd0, busy}, 32'd1);
    n = 1;
    while (!res_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, {30'd0, len} + 32'd2);
  endtask

  task automatic finish_op(input string tag, input logic [31:0] ef, input logic [3:0] efl);
    chk({tag, "_f"}, res_f, ef);
    chk({tag, "_flags_cznv"}, {28'd0, res_co, res_zo, res_no, res_vo}, {28'd0, efl});
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk({tag, "_back_idle"}, {30'd0, res_valid, cmd_ready}, 32'd1);
  endtask

  task automatic op_vec(input string tag, input logic [1:0] op, input logic [1:0] len,
                        input logic [31:0] r, input logic [31:0] s, input logic ci,
                        input logic [31:0] ef, input logic [3:0] efl);
    issue(op, len, r, s, ci);
    finish_op(tag, ef, efl);
  endtask

  initial begin
    #12;
    chk("reset_outs", {res_f ^ 32'd0}, 32'd0);
    chk("reset_ctl", {26'd0, res_valid, busy, res_co, res_zo, res_no, res_vo}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", {31'd0, cmd_ready}, 32'd1);
    // flags ordered {co, zo, no, vo}
    op_vec("add_ff_01",   OP_ADD, 2'd3, 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 4'b0000);
    op_vec("sub_0_1",     OP_SUB, 2'd3, 32'h0000_0001, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 4'b0010);
    op_vec("add_ovf",     OP_ADD, 2'd3, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 4'b0011);
    op_vec("add_len0",    OP_ADD, 2'd0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0000, 4'b1100);
    op_vec("xor_eq",      OP_XOR, 2'd3, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b1, 32'h0000_0000, 4'b0100);
    op_vec("or_len1",     OP_OR,  2'd1, 32'h1234_5600, 32'hFF00_00F0, 1'b1, 32'h0000_56F0, 4'b0000);
    op_vec("sub_len1",    OP_SUB, 2'd1, 32'h1100_0001, 32'hAB00_0100, 1'b1, 32'h0000_00FF, 4'b1000);
    op_vec("add_len2_v",  OP_ADD, 2'd2, 32'h0040_0000, 32'h0040_0000, 1'b0, 32'h0080_0000, 4'b0011);
    // result held under back-pressure while a new command is waiting
    issue(OP_ADD, 2'd0, 32'h0000_0001, 32'h0000_0002, 1'b0);
    {cmd_op, cmd_len, cmd_r, cmd_s, cmd_ci} = {OP_ADD, 2'd1, 32'h0000_00FF, 32'h0000_00FF, 1'b1};
    cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("stall_hold", {res_f[29:0], res_valid, cmd_ready}, {30'd3, 1'b1, 1'b0});
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    op_vec("after_stall", OP_ADD, 2'd1, 32'h0000_00FF, 32'h0000_00FF, 1'b1, 32'h0000_01FF, 4'b0000);
    // reset while byte 2 is in flight
    {cmd_op, cmd_len, cmd_r, cmd_s, cmd_ci} = {OP_ADD, 2'd3, 32'h1111_1111, 32'h2222_2222, 1'b0};
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_outs", res_f, 32'd0);
    chk("rst_mid_ctl", {26'd0, res_valid, busy, res_co, res_zo, res_no, res_vo}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    chk("rst_mid_ready", {31'd0, cmd_ready}, 32'd1);
    begin
      logic seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
        @(posedge clk); #1;
        seen |= res_valid;
      end
      chk("rst_no_result", {31'd0, seen}, 32'd0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
